// File: rtl/post_adder_preg_if.sv
// Operand/result bundle between the X/Y mux stage and the post-adder.
// Signals:
//   CEP                  register clock enable
//   X_MUX_OUT, Y_MUX_OUT signed operands (WIDTH)
//   CIN, OP_SUB, ACC_EN  carry-in, subtract select, accumulate select
//   CLR_OVF, IN_VALID    sticky-overflow clear, operand qualifier
//   P, PCOUT             result and its cascade copy (WIDTH)
//   CARRYOUT, OVF        carry/borrow out, sticky signed overflow
//   OUT_VALID            P holds the result of a valid operation
interface post_adder_preg_if #(
    parameter int unsigned WIDTH = 48
);
    logic             CEP;
    logic [WIDTH-1:0] X_MUX_OUT;
    logic [WIDTH-1:0] Y_MUX_OUT;
    logic             CIN;
    logic             OP_SUB;
    logic             ACC_EN;
    logic             CLR_OVF;
    logic             IN_VALID;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] PCOUT;
    logic             CARRYOUT;
    logic             OVF;
    logic             OUT_VALID;

    // Upstream side: drives operands and controls, observes results.
    modport master (
        output CEP, X_MUX_OUT, Y_MUX_OUT, CIN, OP_SUB, ACC_EN, CLR_OVF, IN_VALID,
        input  P, PCOUT, CARRYOUT, OVF, OUT_VALID
    );

    // Post-adder side.
    modport slave (
        input  CEP, X_MUX_OUT, Y_MUX_OUT, CIN, OP_SUB, ACC_EN, CLR_OVF, IN_VALID,
        output P, PCOUT, CARRYOUT, OVF, OUT_VALID
    );
endinterface

// File: rtl/post_adder_preg.sv
// Post-adder/subtractor with optional P output register.
// Adds or subtracts the Y operand (plus carry-in) to/from either the X operand
// or, when accumulating, the registered P. Produces P, PCOUT, CARRYOUT,
// OUT_VALID (registered when PREG=1, combinational when PREG=0) and a sticky
// signed-overflow flag OVF that is always registered.
// Ports:
//   CLK  clock
//   RST  asynchronous active-high reset
//   bus  post_adder_preg_if.slave operand/result bundle
module post_adder_preg #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned PREG  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    post_adder_preg_if.slave bus
);
    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;
    localparam bit          USE_PREG = (PREG != 0);

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] a_op;
    logic [SW-1:0]    s_ext;
    logic [WIDTH-1:0] sum_c;
    logic             co_c;
    logic             ov_c;
    logic             ovf_q;
    logic             ovf_d;

    // Operand A: feedback of registered P only exists when P is registered.
    always_comb begin
        a_op = bus.X_MUX_OUT;
        if (USE_PREG && bus.ACC_EN) begin
            a_op = p_q;
        end
    end

    // Unsigned add/sub one bit wider so the top bit is carry or borrow.
    always_comb begin
        s_ext = '0;
        if (bus.OP_SUB) begin
            s_ext = {1'b0, a_op} - {1'b0, bus.Y_MUX_OUT} - SW'(bus.CIN);
        end else begin
            s_ext = {1'b0, a_op} + {1'b0, bus.Y_MUX_OUT} + SW'(bus.CIN);
        end
    end

    assign sum_c = s_ext[WIDTH-1:0];
    assign co_c  = s_ext[WIDTH];

    // Signed overflow from operand and result signs (carry-in already folded in).
    always_comb begin
        ov_c = 1'b0;
        if (bus.OP_SUB) begin
            ov_c = (a_op[MSB] != bus.Y_MUX_OUT[MSB]) && (sum_c[MSB] != a_op[MSB]);
        end else begin
            ov_c = (a_op[MSB] == bus.Y_MUX_OUT[MSB]) && (sum_c[MSB] != a_op[MSB]);
        end
    end

    // Sticky overflow next value; clear has priority over a new overflow.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.CLR_OVF) begin
            ovf_d = 1'b0;
        end else if (bus.IN_VALID && ov_c) begin
            ovf_d = 1'b1;
        end
    end

    // Sticky overflow register, present in both build options.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (bus.CEP) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.OVF = ovf_q;

    generate
        if (USE_PREG) begin : g_preg
            logic co_q;
            logic vld_q;

            // P/CARRYOUT/OUT_VALID register; operands are taken whenever enabled.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    p_q   <= '0;
                    co_q  <= 1'b0;
                    vld_q <= 1'b0;
                end else if (bus.CEP) begin
                    p_q   <= sum_c;
                    co_q  <= co_c;
                    vld_q <= bus.IN_VALID;
                end
            end

            assign bus.P         = p_q;
            assign bus.PCOUT     = p_q;
            assign bus.CARRYOUT  = co_q;
            assign bus.OUT_VALID = vld_q;
        end else begin : g_comb
            // No P register: accumulate feedback is unavailable.
            assign p_q           = '0;
            assign bus.P         = sum_c;
            assign bus.PCOUT     = sum_c;
            assign bus.CARRYOUT  = co_c;
            assign bus.OUT_VALID = bus.IN_VALID;
        end
    endgenerate

endmodule

// File: tb/tb_post_adder_preg.sv
`timescale 1ns/1ps
module tb_post_adder_preg;
    localparam int unsigned W = 48;
    localparam logic [W-1:0] ALL1 = 48'hFFFF_FFFF_FFFF;
    localparam logic [W-1:0] MAXP = 48'h7FFF_FFFF_FFFF;
    localparam logic [W-1:0] MINN = 48'h8000_0000_0000;

    logic CLK;
    logic RST;

    post_adder_preg_if #(.WIDTH(W)) bus1 ();
    post_adder_preg_if #(.WIDTH(W)) bus0 ();

    post_adder_preg #(.WIDTH(W), .PREG(1)) u_preg1 (.CLK(CLK), .RST(RST), .bus(bus1));
    post_adder_preg #(.WIDTH(W), .PREG(0)) u_preg0 (.CLK(CLK), .RST(RST), .bus(bus0));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] p;
        logic         co;
        logic         ovf;
        logic         ov;
        int           id;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step_id = 0;

    task automatic check_w(input string name, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    endtask

    task automatic check_b(input string name, input int id, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
    endtask

    // Drive one cycle of operands into the registered DUT and queue the
    // result expected after the following rising edge.
    task automatic drv1(input logic cep, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cin, input logic sub, input logic acc, input logic clr,
                        input logic iv, input logic [W-1:0] ep, input logic eco,
                        input logic eovf, input logic eov);
        exp_t e;
        @(negedge CLK);
        bus1.CEP       = cep;
        bus1.X_MUX_OUT = x;
        bus1.Y_MUX_OUT = y;
        bus1.CIN       = cin;
        bus1.OP_SUB    = sub;
        bus1.ACC_EN    = acc;
        bus1.CLR_OVF   = clr;
        bus1.IN_VALID  = iv;
        step_id++;
        e.p = ep; e.co = eco; e.ovf = eovf; e.ov = eov; e.id = step_id;
        q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the registered outputs
    // against the oldest queued expectation.
    always @(posedge CLK) begin : mon
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_w("P",         e.id, bus1.P,         e.p);
            check_w("PCOUT",     e.id, bus1.PCOUT,     e.p);
            check_b("CARRYOUT",  e.id, bus1.CARRYOUT,  e.co);
            check_b("OVF",       e.id, bus1.OVF,       e.ovf);
            check_b("OUT_VALID", e.id, bus1.OUT_VALID, e.ov);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        bus1.CEP = 1'b0; bus1.X_MUX_OUT = '0; bus1.Y_MUX_OUT = '0; bus1.CIN = 1'b0;
        bus1.OP_SUB = 1'b0; bus1.ACC_EN = 1'b0; bus1.CLR_OVF = 1'b0; bus1.IN_VALID = 1'b0;
        bus0.CEP = 1'b0; bus0.X_MUX_OUT = '0; bus0.Y_MUX_OUT = '0; bus0.CIN = 1'b0;
        bus0.OP_SUB = 1'b0; bus0.ACC_EN = 1'b0; bus0.CLR_OVF = 1'b0; bus0.IN_VALID = 1'b0;

        #2;
        check_w("rst_P",         0, bus1.P,         '0);
        check_b("rst_CARRYOUT",  0, bus1.CARRYOUT,  1'b0);
        check_b("rst_OVF",       0, bus1.OVF,       1'b0);
        check_b("rst_OUT_VALID", 0, bus1.OUT_VALID, 1'b0);
        check_b("rst_OVF_p0",    0, bus0.OVF,       1'b0);
        #1 RST = 1'b0;

        //   cep   x           y           cin   sub   acc   clr   iv    P            co    ovf   ov
        drv1(1'b1, 48'd10,     48'd3,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 48'd14,      1'b0, 1'b0, 1'b1);
        drv1(1'b1, 48'd10,     48'd3,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 48'd6,       1'b0, 1'b0, 1'b1);
        drv1(1'b1, ALL1,       48'd1,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 48'd0,       1'b1, 1'b0, 1'b1);
        drv1(1'b1, 48'd0,      48'd1,      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALL1,        1'b1, 1'b0, 1'b1);
        drv1(1'b1, MAXP,       48'd1,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MINN,        1'b0, 1'b1, 1'b1);
        drv1(1'b1, 48'd1,      48'd1,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 48'd2,       1'b0, 1'b1, 1'b1);
        drv1(1'b1, MAXP,       48'd1,      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, MINN,        1'b0, 1'b0, 1'b1);
        drv1(1'b1, MINN,       48'd1,      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MAXP,        1'b0, 1'b1, 1'b1);
        drv1(1'b1, 48'd0,      48'd0,      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 48'd0,       1'b0, 1'b0, 1'b1);
        // Accumulate; X carries junk that must be ignored.
        drv1(1'b1, 48'd123,    48'd7,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 48'd7,       1'b0, 1'b0, 1'b1);
        drv1(1'b1, 48'd123,    48'd7,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 48'd14,      1'b0, 1'b0, 1'b1);
        drv1(1'b1, 48'd123,    48'd7,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 48'd21,      1'b0, 1'b0, 1'b1);
        drv1(1'b1, 48'd123,    48'd7,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 48'd28,      1'b0, 1'b0, 1'b1);
        // CEP low: everything holds, including OUT_VALID.
        drv1(1'b0, 48'd123,    48'd7,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'd28,      1'b0, 1'b0, 1'b1);
        drv1(1'b0, MAXP,       48'd7,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'd28,      1'b0, 1'b0, 1'b1);
        // IN_VALID low with CEP high: P still advances.
        drv1(1'b1, 48'd123,    48'd7,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'd35,      1'b0, 1'b0, 1'b0);
        drv1(1'b1, MAXP,       48'd1,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MINN,        1'b0, 1'b1, 1'b1);

        // Asynchronous reset pulse between clock edges.
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check_w("midrst_P",         100, bus1.P,         '0);
        check_w("midrst_PCOUT",     100, bus1.PCOUT,     '0);
        check_b("midrst_CARRYOUT",  100, bus1.CARRYOUT,  1'b0);
        check_b("midrst_OVF",       100, bus1.OVF,       1'b0);
        check_b("midrst_OUT_VALID", 100, bus1.OUT_VALID, 1'b0);
        #1 RST = 1'b0;

        drv1(1'b1, 48'd999,    48'd5,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 48'd5,       1'b0, 1'b0, 1'b1);

        // Combinational build: result visible in the same cycle.
        @(negedge CLK);
        bus1.CEP = 1'b0;
        bus0.CEP = 1'b1; bus0.X_MUX_OUT = 48'd100; bus0.Y_MUX_OUT = 48'd50; bus0.CIN = 1'b0;
        bus0.OP_SUB = 1'b1; bus0.ACC_EN = 1'b0; bus0.CLR_OVF = 1'b0; bus0.IN_VALID = 1'b1;
        #1;
        check_w("p0_P",         200, bus0.P,         48'd50);
        check_w("p0_PCOUT",     200, bus0.PCOUT,     48'd50);
        check_b("p0_CARRYOUT",  200, bus0.CARRYOUT,  1'b0);
        check_b("p0_OUT_VALID", 200, bus0.OUT_VALID, 1'b1);
        bus0.ACC_EN = 1'b1;
        #1;
        check_w("p0_acc_P",     201, bus0.P,         48'd50);
        bus0.ACC_EN = 1'b0; bus0.X_MUX_OUT = MAXP; bus0.Y_MUX_OUT = 48'd1; bus0.OP_SUB = 1'b0;
        #1;
        check_w("p0_ovf_P",     202, bus0.P,         MINN);
        check_b("p0_ovf_pre",   202, bus0.OVF,       1'b0);
        @(posedge CLK); #1;
        check_b("p0_ovf_set",   203, bus0.OVF,       1'b1);
        bus0.CEP = 1'b0; bus0.CLR_OVF = 1'b1;
        @(posedge CLK); #1;
        check_b("p0_clr_nocep", 204, bus0.OVF,       1'b1);
        bus0.CEP = 1'b1;
        @(posedge CLK); #1;
        check_b("p0_clr_wins",  205, bus0.OVF,       1'b0);

        // Every queued expectation must have been consumed.
        repeat (3) @(posedge CLK);
        #2;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
